// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, good-byte counter
// and a retriggerable activity LED.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT    = 5,
    parameter int unsigned LED_HOLD_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        framing_error,
    output logic        receive_led,
    output logic [15:0] byte_count
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned LedW = $clog2(LED_HOLD_CYCLES + 1);

    localparam logic [CntW-1:0] HalfCnt = CntW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [LedW-1:0] LedLoad = LedW'(LED_HOLD_CYCLES);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitHigh = 3'd4;

    logic            rx_meta_q, rx_s_q;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic [15:0]     byte_count_q, byte_count_d;
    logic [LedW-1:0] led_cnt_q, led_cnt_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        ferr_d       = 1'b0;
        byte_count_d = byte_count_q;
        led_cnt_d    = (led_cnt_q != '0) ? led_cnt_q - LedW'(1) : '0;

        case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfCnt) begin
                    // A start bit that is gone by mid-bit is treated as a glitch.
                    if (!rx_s_q) begin
                        state_d = StData;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == LastCnt) begin
                    shift_d[idx_q] = rx_s_q;
                    cnt_d          = '0;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                    if (rx_s_q) begin
                        data_d       = shift_q;
                        valid_d      = 1'b1;
                        byte_count_d = byte_count_q + 16'd1;
                        led_cnt_d    = LedLoad;
                        state_d      = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitHigh: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            byte_count_q <= '0;
            led_cnt_q    <= '0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
            byte_count_q <= byte_count_d;
            led_cnt_q    <= led_cnt_d;
        end
    end

    assign data_out      = data_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign byte_count    = byte_count_q;
    assign receive_led   = (led_cnt_q != '0);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial driver queues the expected outcome of each
// frame and a monitor checks every pulse, plus LED and data_out behaviour per cycle.
module tb_uart_rx;

    localparam int CPB = 5;
    localparam int LED = 20;
    // Start edge driven just after posedge N shows up as a pulse after posedge N+51.
    localparam int LATENCY = 51;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        framing_error;
    logic        receive_led;
    logic [15:0] byte_count;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rst_at_edge = 1'b0;
    int   preload_evt = 0;
    int   preload_seen = 0;
    exp_t exp_q[$];

    // Reference state owned by the monitor.
    exp_t        e_mon;
    logic [7:0]  last_good = 8'h00;
    logic [15:0] cnt_model = 16'h0000;
    int          led_rem = 0;

    uart_rx #(
        .CLKS_PER_BIT   (CPB),
        .LED_HOLD_CYCLES(LED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .framing_error(framing_error),
        .receive_led  (receive_led),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (preload_evt != preload_seen) begin
            preload_seen = preload_evt;
            cnt_model    = 16'hFFFF;
        end
        if (rst_at_edge) begin
            check("reset_outputs",
                  int'({data_out, data_valid, framing_error, receive_led, byte_count}), 0);
            exp_q.delete();
            last_good = 8'h00;
            cnt_model = 16'h0000;
            led_rem   = 0;
        end else begin
            check("valid_and_ferr_exclusive", int'(data_valid & framing_error), 0);
            if (data_valid || framing_error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'({data_valid, framing_error}), 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    tests++;
                    if (cyc < e_mon.due - 1 || cyc > e_mon.due + 1) begin
                        fails++;
                        $display("FAIL pulse_timing: got cycle %0d, expected %0d +/-1",
                                 cyc, e_mon.due);
                    end
                    check("pulse_kind", int'(framing_error), int'(e_mon.err));
                    if (!e_mon.err) begin
                        last_good = e_mon.data;
                        cnt_model = cnt_model + 16'd1;
                        led_rem   = LED;
                        check("byte_count", int'(byte_count), int'(cnt_model));
                    end
                end
            end
            check("data_out", int'(data_out), int'(last_good));
            check("receive_led", int'(receive_led), int'(led_rem > 0));
            if (led_rem > 0) led_rem--;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        wait_cycles(CPB);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        wait_cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
        exp_q.push_back('{err: !stop_ok, data: b, due: cyc + LATENCY});
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (gap > 0) idle(gap);
    endtask

    task automatic glitch(input int low_cycles);
        rx = 1'b0;
        wait_cycles(low_cycles);
        idle(10);
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        idle(10);

        send_frame(8'hA5, 1'b1, 10);
        glitch(2);
        send_frame(8'h3B, 1'b1, 10);

        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1, 5);
        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1, 0);
        idle(10);

        // Stop bit low, then a 50-cycle break before recovering.
        send_frame(8'h3C, 1'b0, 0);
        rx = 1'b0;
        wait_cycles(50);
        idle(5);
        send_frame(8'h81, 1'b1, 20);

        // Reset pulse in the middle of data bit 4; this frame is not queued.
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b0;
        wait_cycles(2);
        rx    = 1'b1;
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        idle(20);
        send_frame(8'h5A, 1'b1, 10);

        send_frame(8'hC3, 1'b1, 30);
        send_frame(8'h3E, 1'b1, 30);

        // Byte counter wrap.
        idle(10);
        preload_evt++;
        force dut.byte_count_q = 16'hFFFF;
        wait_cycles(1);
        release dut.byte_count_q;
        idle(5);
        send_frame(8'h11, 1'b1, 10);
        send_frame(8'h22, 1'b1, 10);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) glitch(int'($urandom_range(1, 2)));
            send_frame(8'($urandom_range(0, 255)), 1'b1, int'($urandom_range(0, 6)));
        end

        idle(5);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) wait_cycles(1);
        check("drain_pending", exp_q.size(), 0);
        idle(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 5, meaning clock cycles per UART bit (100 MHz clock / 20 Mbaud); legal range 4..65535.
REQ-002 The module SHALL have parameter LED_HOLD_CYCLES, default 1_000_000, meaning cycles receive_led stays lit after the last good byte; legal range 1..2^24-1.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 The module SHALL have port data_out, output, 8 bits: last received byte.
REQ-007 The module SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_out holds a new good byte.
REQ-008 The module SHALL have port framing_error, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-009 The module SHALL have port receive_led, output, 1 bit: activity indicator.
REQ-010 The module SHALL have port byte_count, output, 16 bits: count of good bytes, wrapping.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions SHALL use the second-flop value (rx_s).
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH, with one shared bit-timing counter and a 3-bit bit index.
REQ-013 IDLE: on rx_s = 0 go to START and clear the counter; otherwise stay.
REQ-014 START: after (CLKS_PER_BIT-1)/2 cycles (integer division), sample rx_s: 0 -> DATA with counter and index cleared; 1 -> IDLE (glitch reject, no output pulse).
REQ-015 DATA: every CLKS_PER_BIT cycles sample rx_s into shift bit [index]; after index 7 go to STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles sample rx_s: 1 -> load data_out, pulse data_valid, increment byte_count, go to IDLE; 0 -> pulse framing_error, leave data_out unchanged, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: stay until rx_s = 1, then go to IDLE; a held-low (break) line SHALL NOT generate further bytes or errors.
REQ-018 Returning to IDLE at mid-stop-bit SHALL allow a start bit that begins immediately after the stop bit to be received (zero idle gap between frames).
REQ-019 data_valid SHALL be registered and asserted on the cycle after the stop-bit sample; data_valid and framing_error SHALL never be high together.
REQ-020 data_out SHALL be stable from its data_valid pulse until the next data_valid.
REQ-021 byte_count SHALL wrap from 0xFFFF to 0x0000.
REQ-022 receive_led SHALL go high on the cycle of data_valid and remain high for LED_HOLD_CYCLES cycles; a new data_valid SHALL reload the hold counter (retrigger); framing errors SHALL NOT light it.
REQ-023 Counters SHALL be sized by $clog2 of their parameter maximum; no arithmetic SHALL overflow within legal parameter ranges.

Reset
REQ-024 While reset is high at a rising clk edge, the FSM SHALL go to IDLE; the synchronizer flops SHALL go to 1; data_out, data_valid, framing_error, receive_led, and byte_count SHALL go to 0; the LED counter SHALL go to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception SHALL resume at the next falling edge seen while in IDLE; a line that is low at release SHALL be treated as a start bit.

Verification
REQ-026 CLKS_PER_BIT=5: send 0xA5 with a uart_tx model -> exactly one data_valid, data_out=0xA5, byte_count=1, receive_led=1.
REQ-027 Send 256 back-to-back bytes 0x00..0xFF with 5-cycle idle gaps, then with 0-cycle gaps -> 256 data_valid pulses each, values in order, no framing_error.
REQ-028 Send a 2-cycle low glitch on idle rx -> no data_valid, no framing_error, FSM back in IDLE.
REQ-029 Send a frame of 0x3C with the stop bit forced low, hold rx low for 50 cycles, then send 0x81 -> one framing_error, data_out stays at the previous value; then data_valid with 0x81.
REQ-030 Assert reset for 1 cycle during bit 4 of a frame -> no pulse, all outputs 0; the next full frame 0x5A is received correctly.
REQ-031 Set LED_HOLD_CYCLES=20 and send two bytes 30 cycles apart -> receive_led low for the gap after cycle 20, relit on the second data_valid; preload byte_count=0xFFFF via 65535 bytes (or force) plus one byte -> 0x0000.
